tdes_engine: RTL

Iterative Triple-DES datapath sitting directly downstream of the AHB-Lite slave controller. It consumes the controller's `enable` strobe, `encryptionType`, `data`, and `key1`–`key3`. It runs a three-pass EDE (or DED) sequence using one Feistel round per clock. It returns the result on `outputData` with `outputEnable`, which the controller samples on reads.

---
 rtl/tdes_engine_pkg.sv | 88 ++++++++
 rtl/tdes_engine_if.sv | 22 ++
 rtl/tdes_engine_des_round.sv | 30 +++
 rtl/tdes_engine.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tdes_engine_pkg.sv
// Shared DES tables, FSM state type and permutation/rotation helpers for the
// iterative Triple-DES engine. Tables hold 1-based DES bit numbers, MSB first.
package tdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KEYLOAD = 2'd1,
    ST_ROUND   = 2'd2,
    ST_FINISH  = 2'd3
  } tdes_state_t;

  localparam logic [511:0] IP_T = 512'h3A322A221A120A02_3C342C241C140C04_3E362E261E160E06_4038302820181008_3931292119110901_3B332B231B130B03_3D352D251D150D05_3F372F271F170F07;
  localparam logic [511:0] FP_T = 512'h2808301038184020_27072F0F37173F1F_26062E0E36163E1E_25052D0D35153D1D_24042C0C34143C1C_23032B0B33133B1B_22022A0A32123A1A_2101290931113919;
  localparam logic [511:0] E_T = {384'h200102030405_040506070809_08090A0B0C0D_0C0D0E0F1011_101112131415_141516171819_18191A1B1C1D_1C1D1E1F2001, 128'd0};
  localparam logic [511:0] P_T = {256'h10071415_1D0C1C11_010F171A_05121F0A_0208180E_201B0309_130D1E06_160B0419, 256'd0};
  localparam logic [511:0] PC1_T = {448'h39312921191109_013A322A221A12_0A023B332B231B_130B033C342C24_3F372F271F170F_073E362E261E16_0E063D352D251D_150D051C140C04, 64'd0};
  localparam logic [511:0] PC2_T = {384'h0E110B180105_031C0F06150A_17130C041A08_10071B140D02_29341F252F37_1E28332D2130_2C3127382235_2E2A32241D20, 128'd0};

  // Bit r set means round r rotates by one position, otherwise by two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  // Each box: 64 nibbles, entry (row*16 + col) with entry 0 in the top nibble.
  localparam logic [255:0] S_BOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Output bits are shifted in MSB first; the result sits right-aligned.
  function automatic logic [63:0] permute(input logic [63:0] x, input logic [511:0] tbl,
                                          input int n_in, input int n_out);
    logic [63:0]  y;
    logic [511:0] tb;
    logic [7:0]   t;
    y  = 64'd0;
    tb = tbl;
    for (int i = 0; i < n_out; i++) begin
      t  = tb[511:504];
      tb = tb << 8;
      y  = {y[62:0], x[6'(n_in - int'(t))]};
    end
    return y;
  endfunction

  function automatic logic [63:0] ip(input logic [63:0] x);
    return permute(x, IP_T, 32'd64, 32'd64);
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    return permute(x, FP_T, 32'd64, 32'd64);
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    return 56'(permute(k, PC1_T, 32'd64, 32'd56));
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    return 48'(permute({8'd0, cd}, PC2_T, 32'd56, 32'd48));
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] r);
    return 48'(permute({32'd0, r}, E_T, 32'd32, 32'd48));
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    return 32'(permute({32'd0, s}, P_T, 32'd32, 32'd32));
  endfunction

  function automatic logic [3:0] sbox(input logic [255:0] tbl, input logic [5:0] b);
    logic [255:0] s;
    s = tbl << {b[5], b[0], b[4:1], 2'b00};
    return s[255:252];
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/tdes_engine_if.sv
// Request/result bundle between the AHB-Lite slave controller and the engine.
interface tdes_engine_if;
  logic        enable;
  logic        encryptionType;
  logic [63:0] data;
  logic [63:0] key1;
  logic [63:0] key2;
  logic [63:0] key3;
  logic        outputEnable;
  logic [63:0] outputData;
  logic        busy;

  modport master (
    output enable, encryptionType, data, key1, key2, key3,
    input  outputEnable, outputData, busy
  );

  modport slave (
    input  enable, encryptionType, data, key1, key2, key3,
    output outputEnable, outputData, busy
  );
endinterface

// File: rtl/tdes_engine_des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
module des_round
  import tdes_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o
);

  logic [47:0] x_s;
  logic [47:0] xt_s;
  logic [31:0] s_s;

  // Expansion, key mix and the eight S-box lookups, six bits at a time from the top.
  always_comb begin
    x_s  = e_exp(r_i) ^ k_i;
    xt_s = x_s;
    s_s  = 32'd0;
    for (int i = 0; i < 8; i++) begin
      s_s  = {s_s[27:0], sbox(S_BOX[i], xt_s[47:42])};
      xt_s = xt_s << 6;
    end
  end

  assign l_o = r_i;
  assign r_o = l_i ^ p_perm(s_s);

endmodule

// File: rtl/tdes_engine.sv
// Iterative Triple-DES engine: one Feistel round per clock, three passes per
// block (E-D-E to encrypt, D-E-D to decrypt), 54-cycle fixed latency.
module tdes_engine
  import tdes_pkg::*;
(
  input  logic         HCLK,
  input  logic         HRESET,
  tdes_engine_if.slave bus
);

  tdes_state_t state_q, state_d;
  logic [1:0]  pass_q, pass_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic [63:0] block_q, block_d;
  logic [63:0] key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;
  logic [55:0] cd_q, cd_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_en_q, out_en_d;
  logic        busy_q, busy_d;

  logic        pass_dec_s;
  logic [3:0]  sh_idx_s;
  logic [1:0]  amt_s;
  logic [55:0] cd_rot_s;
  logic [63:0] key_sel_s;
  logic [31:0] l_next_s, r_next_s;

  // Middle pass runs opposite to the outer passes; decrypt mode starts with D.
  assign pass_dec_s = mode_q ? (pass_q == 2'd1) : (pass_q != 2'd1);
  // Decryption walks the schedule backwards: round r undoes shift (16 - r) mod 16.
  assign sh_idx_s   = pass_dec_s ? (4'd0 - round_q) : round_q;

  // Pass key mux and per-round C/D rotation.
  always_comb begin
    amt_s = SHIFT_ONE[sh_idx_s] ? 2'd1 : 2'd2;
    case ({mode_q, pass_q})
      3'b1_00: key_sel_s = key1_q;
      3'b1_10: key_sel_s = key3_q;
      3'b0_00: key_sel_s = key3_q;
      3'b0_10: key_sel_s = key1_q;
      default: key_sel_s = key2_q;
    endcase
    if (!pass_dec_s) begin
      cd_rot_s = {rotl28(cd_q[55:28], amt_s), rotl28(cd_q[27:0], amt_s)};
    end else if (round_q == 4'd0) begin
      cd_rot_s = cd_q;
    end else begin
      cd_rot_s = {rotr28(cd_q[55:28], amt_s), rotr28(cd_q[27:0], amt_s)};
    end
  end

  des_round u_round (
    .l_i (l_q),
    .r_i (r_q),
    .k_i (pc2(cd_rot_s)),
    .l_o (l_next_s),
    .r_o (r_next_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    round_d    = round_q;
    mode_d     = mode_q;
    block_d    = block_q;
    key1_d     = key1_q;
    key2_d     = key2_q;
    key3_d     = key3_q;
    cd_d       = cd_q;
    l_d        = l_q;
    r_d        = r_q;
    out_data_d = out_data_q;
    out_en_d   = out_en_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          block_d  = bus.data;
          key1_d   = bus.key1;
          key2_d   = bus.key2;
          key3_d   = bus.key3;
          mode_d   = bus.encryptionType;
          out_en_d = 1'b0;
          busy_d   = 1'b1;
          pass_d   = 2'd0;
          state_d  = ST_KEYLOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_KEYLOAD: begin
        cd_d       = pc1(key_sel_s);
        {l_d, r_d} = ip(block_q);
        round_d    = 4'd0;
        state_d    = ST_ROUND;
      end
      ST_ROUND: begin
        cd_d    = cd_rot_s;
        l_d     = l_next_s;
        r_d     = r_next_s;
        round_d = round_q + 4'd1;
        if (round_q == 4'd15) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_FINISH: begin
        block_d = fp({r_q, l_q});
        if (pass_q != 2'd2) begin
          pass_d  = pass_q + 2'd1;
          state_d = ST_KEYLOAD;
        end else begin
          out_data_d = fp({r_q, l_q});
          out_en_d   = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything including the in-flight block.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      pass_q     <= 2'd0;
      round_q    <= 4'd0;
      mode_q     <= 1'b0;
      block_q    <= 64'd0;
      key1_q     <= 64'd0;
      key2_q     <= 64'd0;
      key3_q     <= 64'd0;
      cd_q       <= 56'd0;
      l_q        <= 32'd0;
      r_q        <= 32'd0;
      out_data_q <= 64'd0;
      out_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      round_q    <= round_d;
      mode_q     <= mode_d;
      block_q    <= block_d;
      key1_q     <= key1_d;
      key2_q     <= key2_d;
      key3_q     <= key3_d;
      cd_q       <= cd_d;
      l_q        <= l_d;
      r_q        <= r_d;
      out_data_q <= out_data_d;
      out_en_q   <= out_en_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.outputEnable = out_en_q;
  assign bus.outputData   = out_data_q;
  assign bus.busy         = busy_q;

endmodule
